// File: rtl/idex_hazard_stage_pkg.sv
// Purpose: shared types and defaults for the LEGv8 ID/EX stage (control bundle, ALUOp codes, widths).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package idex_hazard_stage_pkg;

    localparam int DATA_W_DEF = 64;   // operand / immediate width
    localparam int REG_W_DEF  = 5;    // register-number width
    localparam int ZR_IDX     = 31;   // XZR, never a load-use source
    localparam int CNT_W_DEF  = 32;   // performance counter width
    localparam int CTRL_W     = 9;

    // ALUOp encodings produced by the main decoder
    typedef enum logic [1:0] {
        ALUOP_LDST  = 2'b00,
        ALUOP_CBZ   = 2'b01,
        ALUOP_RTYPE = 2'b10
    } aluop_e;

    // Field order matches the flat 9-bit bus:
    // {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,Branch,Uncond,ALUOp[1:0]}
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic       uncond;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/idex_hazard_stage_if.sv
// Purpose: ID-side instruction bundle into the ID/EX stage and registered EX-side bundle out of it.
// Latency: n/a (wires only).
// Backpressure: none on the bus itself; stalls are signalled by the stage's pc_write/ifid_write.
// Ports: master = decode side (drives id_*, reads ex_*); slave = ID/EX stage (reads id_*, drives ex_*).
interface idex_hazard_stage_if
    import idex_hazard_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
);

    // decode side
    logic              id_valid;
    logic [REG_W-1:0]  id_rn;
    logic [REG_W-1:0]  id_rm;        // already Reg2Loc-muxed
    logic [REG_W-1:0]  id_rd;
    logic              id_uses_rm;
    logic [DATA_W-1:0] id_rd1;
    logic [DATA_W-1:0] id_rd2;
    logic [DATA_W-1:0] id_imm;
    ctrl_t             id_ctrl;

    // execute side (IDEX_Register*)
    logic              ex_valid;
    logic [REG_W-1:0]  ex_rn;
    logic [REG_W-1:0]  ex_rm;
    logic [REG_W-1:0]  ex_rd;
    logic [DATA_W-1:0] ex_rd1;
    logic [DATA_W-1:0] ex_rd2;
    logic [DATA_W-1:0] ex_imm;
    ctrl_t             ex_ctrl;

    modport master (
        output id_valid, id_rn, id_rm, id_rd, id_uses_rm, id_rd1, id_rd2, id_imm, id_ctrl,
        input  ex_valid, ex_rn, ex_rm, ex_rd, ex_rd1, ex_rd2, ex_imm, ex_ctrl
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_rd, id_uses_rm, id_rd1, id_rd2, id_imm, id_ctrl,
        output ex_valid, ex_rn, ex_rm, ex_rd, ex_rd1, ex_rd2, ex_imm, ex_ctrl
    );

endinterface

// File: rtl/idex_hazard_stage_sat_counter.sv
// Purpose: event counter that sticks at all-ones instead of wrapping.
// Latency: count visible 1 cycle after inc.
// Backpressure: none; inc is sampled every cycle.
// Ports: clk, clr_n (async active-low clear), inc (count this cycle), cnt (current value).
module idex_hazard_stage_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/idex_hazard_stage.sv
// Purpose: LEGv8 ID/EX pipeline register with load-use detection, branch flush and stall/flush counters.
// Latency: 1 cycle ID->EX; hazard_stall/pc_write/ifid_write are combinational.
// Backpressure: freeze holds the whole stage; a load-use holds PC and IF/ID for exactly one bubble.
// Ports: clk, rst_n, freeze, flush; idex (slave: id_* in, ex_* out); pc_write, ifid_write,
//        hazard_stall; stall_cnt, flush_cnt (saturating).
module idex_hazard_stage
    import idex_hazard_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF,
    parameter int ZR     = ZR_IDX,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                freeze,
    input  logic                flush,
    idex_hazard_stage_if.slave  idex,
    output logic                pc_write,
    output logic                ifid_write,
    output logic                hazard_stall,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    logic              ex_valid_q, ex_valid_d;
    logic [REG_W-1:0]  ex_rn_q,    ex_rn_d;
    logic [REG_W-1:0]  ex_rm_q,    ex_rm_d;
    logic [REG_W-1:0]  ex_rd_q,    ex_rd_d;
    logic [DATA_W-1:0] ex_rd1_q,   ex_rd1_d;
    logic [DATA_W-1:0] ex_rd2_q,   ex_rd2_d;
    logic [DATA_W-1:0] ex_imm_q,   ex_imm_d;
    ctrl_t             ex_ctrl_q,  ex_ctrl_d;

    logic load_in_ex;
    logic hazard;

    // A load writing XZR produces nothing a consumer could wait for.
    assign load_in_ex = ex_valid_q && ex_ctrl_q.mem_read && (ex_rd_q != REG_W'(ZR));

    // Rm only matters for instructions that actually read it; I-type carries a stale Rm field.
    assign hazard = load_in_ex && idex.id_valid &&
                    ((ex_rd_q == idex.id_rn) ||
                     (idex.id_uses_rm && (ex_rd_q == idex.id_rm)));

    // Flush outranks everything: the consumer is being squashed upstream too, so the front end
    // must keep moving to fetch the branch target.
    assign hazard_stall = hazard && !flush && !freeze;
    assign pc_write     = flush || (!freeze && !hazard);
    assign ifid_write   = pc_write;

    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_rn_d    = ex_rn_q;
        ex_rm_d    = ex_rm_q;
        ex_rd_d    = ex_rd_q;
        ex_rd1_d   = ex_rd1_q;
        ex_rd2_d   = ex_rd2_q;
        ex_imm_d   = ex_imm_q;
        ex_ctrl_d  = ex_ctrl_q;

        if (flush || hazard_stall) begin
            // Squash or bubble: an all-zero entry, so MemRead drops and the hazard
            // cannot re-fire against the same consumer next cycle.
            ex_valid_d = 1'b0;
            ex_rn_d    = '0;
            ex_rm_d    = '0;
            ex_rd_d    = '0;
            ex_rd1_d   = '0;
            ex_rd2_d   = '0;
            ex_imm_d   = '0;
            ex_ctrl_d  = CTRL_NOP;
        end else if (!freeze) begin
            ex_valid_d = idex.id_valid;
            ex_rn_d    = idex.id_rn;
            ex_rm_d    = idex.id_rm;
            ex_rd_d    = idex.id_rd;
            ex_rd1_d   = idex.id_rd1;
            ex_rd2_d   = idex.id_rd2;
            ex_imm_d   = idex.id_imm;
            ex_ctrl_d  = idex.id_valid ? idex.id_ctrl : CTRL_NOP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            ex_rn_q    <= '0;
            ex_rm_q    <= '0;
            ex_rd_q    <= '0;
            ex_rd1_q   <= '0;
            ex_rd2_q   <= '0;
            ex_imm_q   <= '0;
            ex_ctrl_q  <= CTRL_NOP;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_rn_q    <= ex_rn_d;
            ex_rm_q    <= ex_rm_d;
            ex_rd_q    <= ex_rd_d;
            ex_rd1_q   <= ex_rd1_d;
            ex_rd2_q   <= ex_rd2_d;
            ex_imm_q   <= ex_imm_d;
            ex_ctrl_q  <= ex_ctrl_d;
        end
    end

    assign idex.ex_valid = ex_valid_q;
    assign idex.ex_rn    = ex_rn_q;
    assign idex.ex_rm    = ex_rm_q;
    assign idex.ex_rd    = ex_rd_q;
    assign idex.ex_rd1   = ex_rd1_q;
    assign idex.ex_rd2   = ex_rd2_q;
    assign idex.ex_imm   = ex_imm_q;
    assign idex.ex_ctrl  = ex_ctrl_q;

    // Freeze is not a stall event, and a flush suppresses the stall count.
    idex_hazard_stage_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (hazard_stall),
        .cnt   (stall_cnt)
    );

    idex_hazard_stage_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr_n (rst_n),
        .inc   (flush),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_idex_hazard_stage.sv
// Purpose: self-checking bench for idex_hazard_stage: directed load-use scenarios plus random traffic.
// Latency: checks registered outputs 1 ns after each rising edge, combinational outputs 2 ns after.
// Backpressure: drives freeze/flush directly; a narrow-counter twin shares all stimulus.
module tb_idex_hazard_stage;
    import idex_hazard_stage_pkg::*;

    localparam logic [8:0] C_LDUR = 9'b1_1_0_1_1_0_0_00;
    localparam logic [8:0] C_ADD  = 9'b1_0_0_0_0_0_0_10;
    localparam logic [8:0] C_ADDI = 9'b1_0_0_0_1_0_0_10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        freeze = 1'b0;
    logic        flush = 1'b0;
    logic        pc_write, ifid_write, hazard_stall;
    logic [31:0] stall_cnt, flush_cnt;
    logic        s_pc_write, s_ifid_write, s_hazard_stall;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    idex_hazard_stage_if #(.DATA_W(64), .REG_W(5)) bus ();
    idex_hazard_stage_if #(.DATA_W(64), .REG_W(5)) sbus ();

    idex_hazard_stage #(.DATA_W(64), .REG_W(5), .ZR(31), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .idex(bus),
        .pc_write(pc_write), .ifid_write(ifid_write), .hazard_stall(hazard_stall),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // 2-bit counters: saturation reached after three events
    assign sbus.id_valid   = bus.id_valid;
    assign sbus.id_rn      = bus.id_rn;
    assign sbus.id_rm      = bus.id_rm;
    assign sbus.id_rd      = bus.id_rd;
    assign sbus.id_uses_rm = bus.id_uses_rm;
    assign sbus.id_rd1     = bus.id_rd1;
    assign sbus.id_rd2     = bus.id_rd2;
    assign sbus.id_imm     = bus.id_imm;
    assign sbus.id_ctrl    = bus.id_ctrl;

    idex_hazard_stage #(.DATA_W(64), .REG_W(5), .ZR(31), .CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .idex(sbus),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write), .hazard_stall(s_hazard_stall),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                         input logic [4:0] rd, input logic um, input logic [8:0] c,
                         input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] im);
        bus.id_valid   = v;
        bus.id_rn      = rn;
        bus.id_rm      = rm;
        bus.id_rd      = rd;
        bus.id_uses_rm = um;
        bus.id_ctrl    = c;
        bus.id_rd1     = d1;
        bus.id_rd2     = d2;
        bus.id_imm     = im;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 9'd0, 64'd0, 64'd0, 64'd0);
    endtask

    task automatic do_reset();
        idle();
        flush = 1'b0;
        freeze = 1'b0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        #12 rst_n = 1'b1;
        tick();
        drive(1'b1, 5'd1, 5'd0, 5'd2, 1'b0, C_LDUR, 64'h5, 64'h6, 64'h7);
        tick();
        drive(1'b1, 5'd2, 5'd4, 5'd3, 1'b1, C_ADD, 64'h1, 64'h2, 64'h0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b1, 5'd1, 5'd0, 5'd2, 1'b0, C_LDUR, 64'h5, 64'h6, 64'h7);
        tick();
        rst_n = 1'b0;
        #1;
        total++; if (bus.ex_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.ex_valid); else passed++;
        total++; if (bus.ex_ctrl !== 9'd0) $display("FAIL rst_ctrl: got %h want 0", bus.ex_ctrl); else passed++;
        total++; if ({bus.ex_rn, bus.ex_rm, bus.ex_rd} !== 15'd0) $display("FAIL rst_regs: got %h want 0", {bus.ex_rn, bus.ex_rm, bus.ex_rd}); else passed++;
        total++; if ({bus.ex_rd1, bus.ex_rd2, bus.ex_imm} !== 192'd0) $display("FAIL rst_data: got nonzero want 0"); else passed++;
        total++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) $display("FAIL rst_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); else passed++;
        total++; if (pc_write !== 1'b1 || ifid_write !== 1'b1 || hazard_stall !== 1'b0) $display("FAIL rst_comb: got pcw=%b ifw=%b hs=%b want 1 1 0", pc_write, ifid_write, hazard_stall); else passed++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 5'd2, 1'b0, C_LDUR, 64'h11, 64'h22, 64'h8);
        #1;
        total++; if (hazard_stall !== 1'b0) $display("FAIL lu_empty_ex: got %b want 0", hazard_stall); else passed++;
        tick();
        total++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd2 || bus.ex_ctrl !== C_LDUR || bus.ex_rd1 !== 64'h11) $display("FAIL lu_capture: got v=%b rd=%0d ctrl=%h rd1=%h want 1 2 %h 11", bus.ex_valid, bus.ex_rd, bus.ex_ctrl, bus.ex_rd1, C_LDUR); else passed++;
        drive(1'b1, 5'd2, 5'd4, 5'd3, 1'b1, C_ADD, 64'hAA, 64'hBB, 64'h0);
        #1;
        total++; if (hazard_stall !== 1'b1 || pc_write !== 1'b0 || ifid_write !== 1'b0) $display("FAIL lu_detect: got hs=%b pcw=%b ifw=%b want 1 0 0", hazard_stall, pc_write, ifid_write); else passed++;
        tick();
        total++; if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 9'd0) $display("FAIL lu_bubble: got v=%b ctrl=%h want 0 0", bus.ex_valid, bus.ex_ctrl); else passed++;
        total++; if (hazard_stall !== 1'b0 || pc_write !== 1'b1) $display("FAIL lu_no_reassert: got hs=%b pcw=%b want 0 1", hazard_stall, pc_write); else passed++;
        tick();
        total++; if (bus.ex_valid !== 1'b1 || bus.ex_rn !== 5'd2 || bus.ex_rm !== 5'd4 || bus.ex_rd !== 5'd3 || bus.ex_ctrl !== C_ADD || bus.ex_rd2 !== 64'hBB) $display("FAIL lu_consumer: got v=%b rn=%0d rm=%0d rd=%0d ctrl=%h want 1 2 4 3 %h", bus.ex_valid, bus.ex_rn, bus.ex_rm, bus.ex_rd, bus.ex_ctrl, C_ADD); else passed++;
        total++; if (stall_cnt !== 32'd1) $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); else passed++;
        idle();
        tick();
    endtask

    task automatic test_zr_rm_gating();
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 5'd31, 1'b0, C_LDUR, 64'h0, 64'h0, 64'h0);
        tick();
        drive(1'b1, 5'd31, 5'd31, 5'd3, 1'b1, C_ADD, 64'h0, 64'h0, 64'h0);
        #1;
        total++; if (hazard_stall !== 1'b0 || pc_write !== 1'b1) $display("FAIL zr_no_stall: got hs=%b pcw=%b want 0 1", hazard_stall, pc_write); else passed++;
        drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b0, C_LDUR, 64'h0, 64'h0, 64'h0);
        tick();
        drive(1'b1, 5'd1, 5'd5, 5'd6, 1'b0, C_ADDI, 64'h0, 64'h0, 64'h10);
        #1;
        total++; if (hazard_stall !== 1'b0) $display("FAIL rm_unused_no_stall: got %b want 0", hazard_stall); else passed++;
        tick();
        drive(1'b1, 5'd1, 5'd0, 5'd5, 1'b0, C_LDUR, 64'h0, 64'h0, 64'h0);
        tick();
        drive(1'b1, 5'd1, 5'd5, 5'd6, 1'b1, C_ADD, 64'h0, 64'h0, 64'h0);
        #1;
        total++; if (hazard_stall !== 1'b1 || pc_write !== 1'b0) $display("FAIL rm_used_stall: got hs=%b pcw=%b want 1 0", hazard_stall, pc_write); else passed++;
        tick();
        idle();
        tick();
    endtask

    task automatic test_flush_hazard();
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 5'd2, 1'b0, C_LDUR, 64'h0, 64'h0, 64'h0);
        tick();
        drive(1'b1, 5'd2, 5'd4, 5'd3, 1'b1, C_ADD, 64'h0, 64'h0, 64'h0);
        flush = 1'b1;
        #1;
        total++; if (hazard_stall !== 1'b0 || pc_write !== 1'b1 || ifid_write !== 1'b1) $display("FAIL fh_comb: got hs=%b pcw=%b ifw=%b want 0 1 1", hazard_stall, pc_write, ifid_write); else passed++;
        tick();
        flush = 1'b0;
        total++; if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 9'd0) $display("FAIL fh_squash: got v=%b ctrl=%h want 0 0", bus.ex_valid, bus.ex_ctrl); else passed++;
        total++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd1) $display("FAIL fh_cnt: got stall=%0d flush=%0d want 0 1", stall_cnt, flush_cnt); else passed++;
        idle();
        tick();
    endtask

    task automatic test_freeze();
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 5'd2, 1'b0, C_LDUR, 64'h55, 64'h0, 64'h0);
        tick();
        drive(1'b1, 5'd2, 5'd4, 5'd3, 1'b1, C_ADD, 64'h0, 64'h66, 64'h0);
        freeze = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (pc_write !== 1'b0 || ifid_write !== 1'b0 || hazard_stall !== 1'b0) $display("FAIL frz_comb%0d: got pcw=%b ifw=%b hs=%b want 0 0 0", k, pc_write, ifid_write, hazard_stall); else passed++;
            tick();
            total++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd2 || bus.ex_ctrl !== C_LDUR || bus.ex_rd1 !== 64'h55 || stall_cnt !== 32'd0) $display("FAIL frz_hold%0d: got v=%b rd=%0d ctrl=%h cnt=%0d want 1 2 %h 0", k, bus.ex_valid, bus.ex_rd, bus.ex_ctrl, stall_cnt, C_LDUR); else passed++;
        end
        freeze = 1'b0;
        #1;
        total++; if (hazard_stall !== 1'b1) $display("FAIL frz_release_stall: got %b want 1", hazard_stall); else passed++;
        tick();
        total++; if (bus.ex_valid !== 1'b0 || stall_cnt !== 32'd1 || hazard_stall !== 1'b0) $display("FAIL frz_one_bubble: got v=%b cnt=%0d hs=%b want 0 1 0", bus.ex_valid, stall_cnt, hazard_stall); else passed++;
        tick();
        total++; if (bus.ex_ctrl !== C_ADD || bus.ex_rd2 !== 64'h66 || stall_cnt !== 32'd1) $display("FAIL frz_consumer: got ctrl=%h rd2=%h cnt=%0d want %h 66 1", bus.ex_ctrl, bus.ex_rd2, stall_cnt, C_ADD); else passed++;
        idle();
        tick();
    endtask

    task automatic test_saturation();
        int e;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 5'd1, 5'd0, 5'd2, 1'b0, C_LDUR, 64'h0, 64'h0, 64'h0);
            tick();
            drive(1'b1, 5'd2, 5'd4, 5'd3, 1'b1, C_ADD, 64'h0, 64'h0, 64'h0);
            tick();
            e = (k > 3) ? 3 : k;
            total++; if (s_stall_cnt !== 2'(e) || stall_cnt !== 32'(k)) $display("FAIL sat_stall%0d: got small=%0d wide=%0d want %0d %0d", k, s_stall_cnt, stall_cnt, e, k); else passed++;
            tick();
        end
        idle();
        for (int k = 1; k <= 5; k++) begin
            flush = 1'b1;
            tick();
            e = (k > 3) ? 3 : k;
            total++; if (s_flush_cnt !== 2'(e) || flush_cnt !== 32'(k)) $display("FAIL sat_flush%0d: got small=%0d wide=%0d want %0d %0d", k, s_flush_cnt, flush_cnt, e, k); else passed++;
        end
        flush = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive(1'b1, 5'd1, 5'd0, 5'd2, 1'b0, C_LDUR, 64'h0, 64'h0, 64'h0);
        tick();
        drive(1'b1, 5'd2, 5'd4, 5'd3, 1'b1, C_ADD, 64'h9, 64'h0, 64'h0);
        #1;
        total++; if (hazard_stall !== 1'b1) $display("FAIL rms_pre: got %b want 1", hazard_stall); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 9'd0 || bus.ex_rd !== 5'd0 || hazard_stall !== 1'b0 || pc_write !== 1'b1) $display("FAIL rms_clear: got v=%b ctrl=%h rd=%0d hs=%b pcw=%b want 0 0 0 0 1", bus.ex_valid, bus.ex_ctrl, bus.ex_rd, hazard_stall, pc_write); else passed++;
        rst_n = 1'b1;
        tick();
        total++; if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd3 || bus.ex_ctrl !== C_ADD || bus.ex_rd1 !== 64'h9 || stall_cnt !== 32'd0) $display("FAIL rms_capture: got v=%b rd=%0d ctrl=%h cnt=%0d want 1 3 %h 0", bus.ex_valid, bus.ex_rd, bus.ex_ctrl, stall_cnt, C_ADD); else passed++;
        idle();
        tick();
    endtask

    typedef struct {
        bit        v;
        bit [4:0]  rn, rm, rd;
        bit        um;
        bit [8:0]  c;
        bit [63:0] d1, d2, im;
    } instr_t;

    task automatic test_random();
        instr_t ex_m;        // what EX should hold
        instr_t idm;
        instr_t empty;
        bit [4:0] regs [4];
        bit fl, fz, needs_bubble, exp_stall, exp_hold;
        int st, fc;
        regs[0] = 5'd1; regs[1] = 5'd2; regs[2] = 5'd3; regs[3] = 5'd31;
        empty = '{default: 0};
        ex_m = empty;
        st = 0;
        fc = 0;
        do_reset();
        for (int cyc = 0; cyc < 300; cyc++) begin
            idm.v  = ($urandom_range(0, 3) != 0);
            idm.rn = regs[$urandom_range(0, 3)];
            idm.rm = regs[$urandom_range(0, 3)];
            idm.rd = regs[$urandom_range(0, 3)];
            idm.um = $urandom_range(0, 1) == 1;
            idm.c  = ($urandom_range(0, 1) == 1) ? C_LDUR : 9'($urandom);
            idm.d1 = {$urandom, $urandom};
            idm.d2 = {$urandom, $urandom};
            idm.im = {$urandom, $urandom};
            fl = ($urandom_range(0, 7) == 0);
            fz = ($urandom_range(0, 7) == 0);
            drive(idm.v, idm.rn, idm.rm, idm.rd, idm.um, idm.c, idm.d1, idm.d2, idm.im);
            flush = fl;
            freeze = fz;
            #1;
            // Consumer in ID needs a register the load in EX has not fetched yet.
            needs_bubble = ex_m.v && ex_m.c[7] && (ex_m.rd != 5'd31) && idm.v &&
                           (ex_m.rd == idm.rn || (idm.um && ex_m.rd == idm.rm));
            exp_stall = needs_bubble && !fl && !fz;
            exp_hold  = !fl && (fz || needs_bubble);
            total++; if (hazard_stall !== exp_stall || pc_write !== !exp_hold || ifid_write !== !exp_hold) $display("FAIL rnd_comb c%0d: got hs=%b pcw=%b ifw=%b want %b %b %b", cyc, hazard_stall, pc_write, ifid_write, exp_stall, !exp_hold, !exp_hold); else passed++;
            if (fl || exp_stall) begin
                ex_m = empty;
            end else if (!fz) begin
                ex_m = idm;
                if (!idm.v) ex_m.c = 9'd0;
            end
            st += int'(exp_stall);
            fc += int'(fl);
            tick();
            total++; if (bus.ex_valid !== ex_m.v || bus.ex_ctrl !== ex_m.c) $display("FAIL rnd_vc c%0d: got v=%b ctrl=%h want %b %h", cyc, bus.ex_valid, bus.ex_ctrl, ex_m.v, ex_m.c); else passed++;
            if (ex_m.v) begin
                total++; if (bus.ex_rn !== ex_m.rn || bus.ex_rm !== ex_m.rm || bus.ex_rd !== ex_m.rd) $display("FAIL rnd_regs c%0d: got %0d %0d %0d want %0d %0d %0d", cyc, bus.ex_rn, bus.ex_rm, bus.ex_rd, ex_m.rn, ex_m.rm, ex_m.rd); else passed++;
                total++; if (bus.ex_rd1 !== ex_m.d1 || bus.ex_rd2 !== ex_m.d2 || bus.ex_imm !== ex_m.im) $display("FAIL rnd_data c%0d: got %h %h %h want %h %h %h", cyc, bus.ex_rd1, bus.ex_rd2, bus.ex_imm, ex_m.d1, ex_m.d2, ex_m.im); else passed++;
            end
            total++; if (stall_cnt !== 32'(st) || flush_cnt !== 32'(fc)) $display("FAIL rnd_cnt c%0d: got %0d %0d want %0d %0d", cyc, stall_cnt, flush_cnt, st, fc); else passed++;
        end
        flush = 1'b0;
        freeze = 1'b0;
        idle();
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zr_rm_gating();
        test_flush_hazard();
        test_freeze();
        test_saturation();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", passed, total);
        $fatal(1);
    end

endmodule
